// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the IF-stage program-counter logic.
package fetch_pkg;

  // Next-fetch-address source selected by the ID stage.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc_unit_if.sv
// Control/address bundle between the ID stage (master) and the fetch PC unit (slave).
interface fetch_pc_unit_if #(
  parameter int PC_W      = 12,
  parameter int DISP_W    = 8,
  parameter int RAS_DEPTH = 8
);

  // ID-stage requests
  logic                         stall;
  logic [1:0]                   pc_sel;
  logic                         call;
  logic [PC_W-1:0]              id_pc;
  logic [DISP_W-1:0]            branch_disp;
  logic [PC_W-1:0]              jump_target;
  logic                         ras_clear_err;

  // Fetch-unit results
  logic [PC_W-1:0]              pc;
  logic [PC_W-1:0]              next_pc;
  logic                         redirect;
  logic [$clog2(RAS_DEPTH):0]   ras_count;
  logic                         ras_overflow;
  logic                         ras_underflow;

  modport master (
    output stall, pc_sel, call, id_pc, branch_disp, jump_target, ras_clear_err,
    input  pc, next_pc, redirect, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, pc_sel, call, id_pc, branch_disp, jump_target, ras_clear_err,
    output pc, next_pc, redirect, ras_count, ras_overflow, ras_underflow
  );

endinterface : fetch_pc_unit_if

// File: rtl/fetch_pc_unit_ras_circ.sv
// Circular return-address stack: storage, write pointer, occupancy and sticky error flags.
module ras_circ #(
  parameter int  PC_W      = 12,
  parameter int  RAS_DEPTH = 8,
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [PC_W-1:0]  push_data_i,
  input  logic             clear_i,
  output logic [PC_W-1:0]  top_o,
  output logic [PTR_W:0]   count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_addr;
  logic             wr_en;
  logic             full;
  logic             empty;
  logic             ovf_err;
  logic             unf_err;

  assign top_idx = wp_q - PTR_W'(1);
  assign full    = (count_q == (PTR_W+1)'(RAS_DEPTH));
  assign empty   = (count_q == '0);

  assign top_o       = mem_q[top_idx];
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  // Pointer/occupancy/flag next state and the single write port selection.
  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = wp_q;
    ovf_err = 1'b0;
    unf_err = 1'b0;

    unique case ({push_i, pop_i})
      2'b10: begin
        wr_en = 1'b1;
        wp_d  = wp_q + PTR_W'(1);
        if (full) ovf_err = 1'b1;
        else      count_d = count_q + (PTR_W+1)'(1);
      end
      2'b01: begin
        if (empty) begin
          unf_err = 1'b1;
        end else begin
          wp_d    = wp_q - PTR_W'(1);
          count_d = count_q - (PTR_W+1)'(1);
        end
      end
      2'b11: begin
        // Pop-then-push collapses to overwriting the top in place; when empty
        // the pop fails and the push proceeds as a plain first entry.
        wr_en = 1'b1;
        if (empty) begin
          unf_err = 1'b1;
          wp_d    = wp_q + PTR_W'(1);
          count_d = (PTR_W+1)'(1);
        end else begin
          wr_addr = top_idx;
        end
      end
      default: ;
    endcase

    // A fresh error in the clearing cycle takes priority over the clear.
    ovf_d = (ovf_q & ~clear_i) | ovf_err;
    unf_d = (unf_q & ~clear_i) | unf_err;
  end

  // Stack storage; reset zeroes every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= push_data_i;
    end
  end

  // Pointer, occupancy and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule : ras_circ

// File: rtl/fetch_pc_unit.sv
// IF-stage program counter: next-PC selection, stall gating and return-address stack.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int          PC_W      = 12,
  parameter int          DISP_W    = 8,
  parameter int          RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset,
  fetch_pc_unit_if.slave bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  pc_sel_e          sel;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  disp_ext;
  logic [PC_W-1:0]  id_inc;
  logic [PC_W-1:0]  branch_pc;
  logic [PC_W-1:0]  ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_ovf;
  logic             ras_unf;

  assign sel       = pc_sel_e'(bus.pc_sel);
  assign disp_ext  = PC_W'($signed(bus.branch_disp));
  assign id_inc    = bus.id_pc + PC_W'(1);
  assign branch_pc = id_inc + disp_ext;

  assign ras_push  = bus.call & ~bus.stall;
  assign ras_pop   = (sel == PC_RET) & ~bus.stall;

  // Next fetch address; a stall simply re-presents the current PC.
  always_comb begin
    pc_d = pc_q;
    if (!bus.stall) begin
      unique case (sel)
        PC_SEQ:    pc_d = pc_q + PC_W'(1);
        PC_BRANCH: pc_d = branch_pc;
        PC_JUMP:   pc_d = bus.jump_target;
        PC_RET:    pc_d = (ras_count == '0) ? RESET_PC : ras_top;
        default:   pc_d = pc_q;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  ras_circ #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (id_inc),
    .clear_i     (bus.ras_clear_err),
    .top_o       (ras_top),
    .count_o     (ras_count),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_unf)
  );

  assign bus.pc            = pc_q;
  assign bus.next_pc       = pc_d;
  assign bus.redirect      = (sel != PC_SEQ) & ~bus.stall;
  assign bus.ras_count     = ras_count;
  assign bus.ras_overflow  = ras_ovf;
  assign bus.ras_underflow = ras_unf;

endmodule : fetch_pc_unit

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit against a queue-based behavioural model.
module tb_fetch_pc_unit;

  localparam int          PC_W  = 12;
  localparam int          DW    = 8;
  localparam int          DEPTH = 8;
  localparam logic [11:0] RST_PC = 12'h000;

  logic clk;
  logic reset;

  fetch_pc_unit_if #(.PC_W(PC_W), .DISP_W(DW), .RAS_DEPTH(DEPTH)) bus ();

  fetch_pc_unit #(
    .PC_W      (PC_W),
    .DISP_W    (DW),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: PC, stack as a bounded queue (back = top), sticky flags.
  logic [11:0] m_pc;
  logic [11:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;
  logic [11:0] last_next;
  logic        last_redir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle, check combinational outputs, advance the model, check registered outputs.
  task automatic step(input logic [1:0] sel, input logic c, input logic st, input logic clr,
                      input logic [11:0] idpc, input logic [7:0] disp, input logic [11:0] jt);
    logic [11:0] exp_next;
    logic [11:0] ret_val;
    logic        exp_redir;
    logic        eo;
    logic        eu;
    int          sdisp;
    bus.pc_sel        = sel;
    bus.call          = c;
    bus.stall         = st;
    bus.ras_clear_err = clr;
    bus.id_pc         = idpc;
    bus.branch_disp   = disp;
    bus.jump_target   = jt;
    #1;
    sdisp   = int'($signed(disp));
    ret_val = (m_ras.size() == 0) ? RST_PC : m_ras[m_ras.size()-1];
    if (st) exp_next = m_pc;
    else case (sel)
      2'd0:    exp_next = 12'(int'(m_pc) + 1);
      2'd1:    exp_next = 12'(int'(idpc) + 1 + sdisp);
      2'd2:    exp_next = jt;
      default: exp_next = ret_val;
    endcase
    exp_redir  = !st && (sel != 2'd0);
    last_next  = bus.next_pc;
    last_redir = bus.redirect;
    chk("next_pc", 32'(bus.next_pc), 32'(exp_next));
    chk("redirect", 32'(bus.redirect), 32'(exp_redir));

    eo = 1'b0;
    eu = 1'b0;
    if (!st) begin
      if (c && sel == 2'd3) begin
        if (m_ras.size() == 0) begin
          eu = 1'b1;
          m_ras.push_back(idpc + 12'd1);
        end else begin
          m_ras[m_ras.size()-1] = idpc + 12'd1;
        end
      end else if (c) begin
        if (m_ras.size() == DEPTH) begin
          eo = 1'b1;
          void'(m_ras.pop_front());
        end
        m_ras.push_back(idpc + 12'd1);
      end else if (sel == 2'd3) begin
        if (m_ras.size() == 0) eu = 1'b1;
        else void'(m_ras.pop_back());
      end
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    m_ovf = m_ovf | eo;
    m_unf = m_unf | eu;
    m_pc  = exp_next;

    @(posedge clk);
    #1;
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    chk("ras_overflow", 32'(bus.ras_overflow), 32'(m_ovf));
    chk("ras_underflow", 32'(bus.ras_underflow), 32'(m_unf));
  endtask

  // Hard stop if something keeps the run from ending.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] held_pc;
    logic [1:0]  rsel;
    bus.stall = 0; bus.pc_sel = 0; bus.call = 0; bus.id_pc = 0;
    bus.branch_disp = 0; bus.jump_target = 0; bus.ras_clear_err = 0;
    reset = 1'b1;
    model_reset();
    #2;
    chk("reset_pc", 32'(bus.pc), 32'(RST_PC));
    chk("reset_count", 32'(bus.ras_count), 0);
    chk("reset_ovf", 32'(bus.ras_overflow), 0);
    chk("reset_unf", 32'(bus.ras_underflow), 0);
    #10;
    reset = 1'b0;

    // Sequential fetch
    for (int i = 1; i <= 3; i++) begin
      step(2'd0, 0, 0, 0, 12'h000, 8'h00, 12'h000);
      chk("seq_pc", 32'(bus.pc), 32'(i));
    end
    step(2'd0, 1, 0, 0, 12'h020, 8'h00, 12'h000);

    // Asynchronous reset mid-run, observed before any edge
    reset = 1'b1;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'(RST_PC));
    chk("async_rst_count", 32'(bus.ras_count), 0);
    model_reset();
    #2;
    reset = 1'b0;

    // Relative branches, including wrap-around
    step(2'd1, 0, 0, 0, 12'h010, 8'hFC, 12'h000);
    chk("branch_neg", 32'(last_next), 32'h00D);
    step(2'd1, 0, 0, 0, 12'hFFF, 8'h01, 12'h000);
    chk("branch_wrap", 32'(last_next), 32'h001);

    // Jump with call, then return
    step(2'd2, 1, 0, 0, 12'h050, 8'h00, 12'h200);
    chk("jump_pc", 32'(bus.pc), 32'h200);
    chk("jump_count", 32'(bus.ras_count), 1);
    step(2'd3, 0, 0, 0, 12'h000, 8'h00, 12'h000);
    chk("ret_addr", 32'(last_next), 32'h051);

    // Overflow: 9 calls into 8 entries, then drain and underflow
    for (int i = 0; i < 9; i++) step(2'd0, 1, 0, 0, 12'(i), 8'h00, 12'h000);
    chk("ovf_count", 32'(bus.ras_count), 8);
    chk("ovf_flag", 32'(bus.ras_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      step(2'd3, 0, 0, 0, 12'h000, 8'h00, 12'h000);
      chk("drain_ret", 32'(last_next), 32'(9 - i));
    end
    step(2'd3, 0, 0, 0, 12'h000, 8'h00, 12'h000);
    chk("empty_ret", 32'(last_next), 32'(RST_PC));
    chk("unf_flag", 32'(bus.ras_underflow), 1);
    step(2'd0, 0, 0, 1, 12'h000, 8'h00, 12'h000);
    chk("clear_ovf", 32'(bus.ras_overflow), 0);
    chk("clear_unf", 32'(bus.ras_underflow), 0);

    // Return-with-call replaces the top
    step(2'd0, 1, 0, 0, 12'h122, 8'h00, 12'h000);
    step(2'd3, 1, 0, 0, 12'h300, 8'h00, 12'h000);
    chk("retcall_next", 32'(last_next), 32'h123);
    chk("retcall_count", 32'(bus.ras_count), 1);

    // Stall suppresses everything
    held_pc = bus.pc;
    step(2'd3, 1, 1, 0, 12'h444, 8'h00, 12'h000);
    chk("stall_pc", 32'(bus.pc), 32'(held_pc));
    chk("stall_redir", 32'(last_redir), 0);
    chk("stall_count", 32'(bus.ras_count), 1);
    step(2'd3, 0, 0, 0, 12'h000, 8'h00, 12'h000);
    chk("retcall_top", 32'(last_next), 32'h301);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        #1;
        chk("rand_rst_pc", 32'(bus.pc), 32'(RST_PC));
        chk("rand_rst_count", 32'(bus.ras_count), 0);
        model_reset();
        #2;
        reset = 1'b0;
      end
      rsel = 2'($urandom_range(0, 3));
      step(rsel,
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 9) == 0),
           12'($urandom), 8'($urandom), 12'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_pc_unit

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter and return-address unit for the pipelined core's IF stage. Holds the PC, selects the next fetch address (sequential, signed relative branch, absolute jump, return), and owns a circular return-address stack with overflow/underflow reporting. Replaces the inline PC mux and fixed stack in the datapath. Generalises address width, displacement width and stack depth, and adds signed displacements, atomic call-with-return and error flags.

## Interface
- `PC_W`, default 12: PC and return-address width.
- `DISP_W`, default 8: branch displacement width, two's complement, `DISP_W` ≤ `PC_W`.
- `RAS_DEPTH`, default 8: stack entries, power of two, ≥ 2.
- `RESET_PC`, default 0: PC value after reset.
- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hold PC and suppress stack operations.
- `pc_sel` in 2: 00 SEQ, 01 BRANCH, 10 JUMP, 11 RET.
- `call` in 1: push `id_pc`+1 this cycle. Legal with any `pc_sel`.
- `id_pc` in `PC_W`: PC of the instruction in ID.
- `branch_disp` in `DISP_W`: signed displacement from the ID instruction.
- `jump_target` in `PC_W`: absolute target from the ID instruction.
- `ras_clear_err` in 1: clear sticky error flags.
- `pc` out `PC_W`: current fetch address.
- `next_pc` out `PC_W`: combinational next fetch address.
- `redirect` out 1: `pc_sel` ≠ SEQ and not `stall`. The hazard unit uses it to flush IF/ID.
- `ras_count` out `$clog2(RAS_DEPTH)+1`: valid entries, 0..`RAS_DEPTH`.
- `ras_overflow` out 1: sticky. A push occurred while full.
- `ras_underflow` out 1: sticky. A RET occurred while empty.

## Operation
- `next_pc` when `stall`=1: `pc`.
- `next_pc` for SEQ: `pc`+1.
- `next_pc` for BRANCH: `id_pc` + 1 + sign-extend(`branch_disp`).
- `next_pc` for JUMP: `jump_target`.
- `next_pc` for RET: top of stack. If the stack is empty: `RESET_PC`.
- All arithmetic is modulo 2^`PC_W`; wrap-around is silent.
- Push value is always `id_pc`+1, modulo 2^`PC_W`.
- Stack is a circular buffer: write pointer `wp`, top = entry[`wp`-1].
- Push only: write at `wp`, `wp`+1.
  - If `count` < `RAS_DEPTH`: `count`+1.
  - Otherwise `count` holds, the oldest entry is overwritten, and `ras_overflow` is set.
- Pop only (RET, no `call`): if `count` > 0 then `wp`-1, `count`-1.
  - Otherwise pointers hold and `ras_underflow` is set.
- RET with `call`: `next_pc` = old top, then top is replaced by `id_pc`+1. `count` and `wp` are unchanged.
  - If empty: `ras_underflow` is set, then a normal push occurs (`count`=1).
- `stall`=1: no push, no pop, flags unchanged except by `ras_clear_err`.
- `ras_clear_err`: clears both flags. A new error in the same cycle wins (flag set).

## Timing
- `pc` updates to `next_pc` on every rising `clk` edge.
- `next_pc`, `redirect` and the top-of-stack read are combinational, in the same cycle as the inputs.
- Zero-cycle redirect: a RET in ID sees a push made by a `call` in the immediately preceding cycle.
- Stack writes, pointer updates and flag updates take effect on the rising edge.
- Reset (asynchronous assert, mid-operation included):
  - `pc`=`RESET_PC`, `wp`=0, `ras_count`=0, flags 0, all entries 0.
  - Outputs reflect these values immediately, with no clock edge needed.
- After reset deasserts, the first rising edge performs a normal update.

## Structure
- Shared package `fetch_pkg`: `pc_sel` encodings `PC_SEQ`, `PC_BRANCH`, `PC_JUMP`, `PC_RET`.
- Sub-module `ras_circ`: storage array, `wp`, `count`, flags.
  - Ports: push, pop, push data, top, count, overflow, underflow, clear.
  - Parametrised by `PC_W` and `RAS_DEPTH`.
- Top level holds the PC register, next-PC mux, sign-extension adder and stall gating.

## Test plan
- Reset then 3 SEQ cycles -> `pc` = 0, 1, 2, 3. Assert `reset` mid-run -> `pc`=0 and `ras_count`=0 at once, before any edge.
- BRANCH with `id_pc`=0x010, `branch_disp`=0xFC (-4) -> `next_pc`=0x00D. With `id_pc`=0xFFF, disp 0x01 -> `next_pc`=0x001 (wrap).
- JUMP 0x200 with `call`, `id_pc`=0x050 -> `pc`=0x200, `ras_count`=1. Next cycle RET -> `next_pc`=0x051, `ras_count`=0.
- 9 calls with `id_pc`=0..8, `RAS_DEPTH`=8 -> `ras_count`=8 and `ras_overflow`=1. 8 RETs return 9, 8, …, 2. A 9th RET -> `next_pc`=`RESET_PC` and `ras_underflow`=1. `ras_clear_err` -> both flags 0.
- RET+`call` with top=0x123, `id_pc`=0x300 -> `next_pc`=0x123, new top 0x301, `ras_count` unchanged.
- `stall`=1 with `pc_sel`=RET and `call`=1 -> `pc` holds, `redirect`=0, `ras_count` and flags unchanged.
